// File: rtl/pixel_readout_capture.sv
// Captures 2x2 pixel frames from the read1..read4 strobed DATA bus, buffers
// complete frames in a small FIFO and streams pixels out over valid/ready.
module pixel_readout_capture #(
  parameter int DATA_W        = 8,
  parameter int SETTLE_CYCLES = 2,
  parameter int FIFO_FRAMES   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              convert,
  input  logic              read1,
  input  logic              read2,
  input  logic              read3,
  input  logic              read4,
  input  logic [DATA_W-1:0] DATA,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_idx,
  output logic              out_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              seq_err,
  output logic              overflow,
  output logic [7:0]        drop_cnt
);

  localparam int PW = (FIFO_FRAMES > 1) ? $clog2(FIFO_FRAMES) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, SETTLE, HELD} state_t;

  state_t            state_q;
  logic [1:0]        exp_q;
  logic [3:0]        cnt_q;
  logic              conv_q;
  logic              push_pend_q;
  logic              seq_err_q;
  logic [DATA_W-1:0] slot_q [4];

  logic [DATA_W-1:0] mem_q [FIFO_FRAMES][4];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q, count_d;
  logic [1:0]        out_idx_q;
  logic              overflow_q;
  logic [7:0]        drop_q;

  logic [3:0] strb, exp_hot;
  logic       any_hi, multi_hi, conv_rise, strobe_err, conv_err, err_event, err_drop, latch_en;
  logic       xfer, pop, fifo_full, push_acc, ovf_event, drop_inc;

  assign strb       = {read4, read3, read2, read1};
  assign any_hi     = |strb;
  assign multi_hi   = (strb & (strb - 4'd1)) != 4'd0;
  assign exp_hot    = 4'd1 << exp_q;
  assign conv_rise  = convert & ~conv_q;
  assign strobe_err = multi_hi | (any_hi & (strb != exp_hot));
  assign conv_err   = conv_rise & (exp_q != 2'd0);
  assign err_event  = strobe_err | conv_err;
  // A frame only counts as dropped if something of it was already accepted.
  assign err_drop   = conv_err | (strobe_err & ((exp_q != 2'd0) | (state_q == HELD)));
  assign latch_en   = !err_event && any_hi &&
                      (((state_q == IDLE) && (SETTLE_CYCLES == 1)) ||
                       ((state_q == SETTLE) && (cnt_q == 4'(SETTLE_CYCLES - 1))));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      exp_q       <= 2'd0;
      cnt_q       <= 4'd0;
      conv_q      <= 1'b0;
      push_pend_q <= 1'b0;
      seq_err_q   <= 1'b0;
    end else begin
      conv_q      <= convert;
      seq_err_q   <= err_event;
      push_pend_q <= 1'b0;
      if (err_event) begin
        state_q <= IDLE;
        exp_q   <= 2'd0;
        cnt_q   <= 4'd0;
      end else begin
        case (state_q)
          IDLE: if (any_hi) begin
            state_q <= latch_en ? HELD : SETTLE;
            cnt_q   <= 4'd1;
          end
          SETTLE: if (!any_hi) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
          end else if (latch_en) begin
            state_q <= HELD;
            cnt_q   <= 4'd0;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
          HELD: if (!any_hi) begin
            state_q     <= IDLE;
            exp_q       <= exp_q + 2'd1;
            push_pend_q <= (exp_q == 2'd3);
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (latch_en && exp_q == 2'(i)) slot_q[i] <= DATA;
    end
  end

  assign out_valid = count_q != '0;
  assign xfer      = out_valid & out_ready;
  assign pop       = xfer & (out_idx_q == 2'd3);
  assign fifo_full = count_q == CW'(FIFO_FRAMES);
  // Popping the head frame frees its entry for a push in the same cycle.
  assign push_acc  = push_pend_q & (!fifo_full | pop);
  assign ovf_event = push_pend_q & !push_acc;
  assign drop_inc  = err_drop | ovf_event;

  always_comb begin
    count_d = count_q;
    if (push_acc && !pop)      count_d = count_q + CW'(1);
    else if (!push_acc && pop) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      out_idx_q  <= 2'd0;
      overflow_q <= 1'b0;
      drop_q     <= 8'd0;
    end else begin
      if (push_acc) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)      rd_ptr_q <= rd_ptr_q + PW'(1);
      if (xfer)     out_idx_q <= out_idx_q + 2'd1;
      count_q    <= count_d;
      overflow_q <= overflow_q | ovf_event;
      if (drop_inc && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_acc) begin
      for (int i = 0; i < 4; i++) mem_q[wr_ptr_q][i] <= slot_q[i];
    end
  end

  assign out_data = out_valid ? mem_q[rd_ptr_q][out_idx_q] : '0;
  assign out_idx  = out_idx_q;
  assign out_last = out_valid & (out_idx_q == 2'd3);
  assign seq_err  = seq_err_q;
  assign overflow = overflow_q;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_pixel_readout_capture.sv
// Directed bench for pixel_readout_capture: capture, backpressure, sequence
// errors, convert handling, overflow, settle filtering and mid-frame reset.
module tb_pixel_readout_capture;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       convert = 1'b0;
  logic       read1 = 1'b0, read2 = 1'b0, read3 = 1'b0, read4 = 1'b0;
  logic [7:0] DATA = 8'h00;
  logic [7:0] out_data;
  logic [1:0] out_idx;
  logic       out_last, out_valid;
  logic       out_ready = 1'b0;
  logic       seq_err, overflow;
  logic [7:0] drop_cnt;

  int errors = 0;
  int checks = 0;

  pixel_readout_capture #(.DATA_W(8), .SETTLE_CYCLES(2), .FIFO_FRAMES(4)) dut (
    .clk(clk), .reset(reset), .convert(convert),
    .read1(read1), .read2(read2), .read3(read3), .read4(read4),
    .DATA(DATA), .out_data(out_data), .out_idx(out_idx), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .seq_err(seq_err), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
    $display("check %-14s observed %0h expected %0h", tag, got, exp);
  endtask

  task automatic set_strobe(input int n, input logic v);
    case (n)
      1: read1 = v;
      2: read2 = v;
      3: read3 = v;
      default: read4 = v;
    endcase
  endtask

  // Strobe high 3 cycles with DATA stable, then 2 idle cycles.
  task automatic pix(input int n, input logic [7:0] d);
    set_strobe(n, 1'b1);
    DATA = d;
    repeat (3) tick();
    set_strobe(n, 1'b0);
    DATA = 8'h00;
    repeat (2) tick();
  endtask

  task automatic send_frame(input logic [7:0] d1, d2, d3, d4);
    pix(1, d1);
    pix(2, d2);
    pix(3, d3);
    pix(4, d4);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
    check(tag, out_valid, 1);
  endtask

  // Checks the presented pixel, then advances one cycle (a transfer if out_ready).
  task automatic expect_px(input string tag, input logic [7:0] d, input logic [1:0] idx);
    check({tag, "_data"}, out_data, d);
    check({tag, "_idx"}, out_idx, idx);
    check({tag, "_last"}, out_last, idx == 2'd3);
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (2) tick();
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_idx", out_idx, 0);
    check("rst_last", out_last, 0);
    check("rst_seqerr", seq_err, 0);
    check("rst_ovf", overflow, 0);
    check("rst_drop", drop_cnt, 0);
    reset = 1'b0;

    // 1. Basic capture, consumer always ready
    out_ready = 1'b1;
    send_frame(8'h11, 8'h22, 8'h33, 8'h44);
    wait_valid("t1_valid");
    expect_px("t1_p0", 8'h11, 2'd0);
    expect_px("t1_p1", 8'h22, 2'd1);
    expect_px("t1_p2", 8'h33, 2'd2);
    expect_px("t1_p3", 8'h44, 2'd3);
    check("t1_empty", out_valid, 0);

    // 2. Backpressure holds the head pixel stable
    out_ready = 1'b0;
    send_frame(8'h11, 8'h22, 8'h33, 8'h44);
    wait_valid("t2_valid");
    for (int i = 0; i < 5; i++) begin
      check("t2_hold_data", out_data, 8'h11);
      check("t2_hold_idx", out_idx, 0);
      check("t2_hold_vld", out_valid, 1);
      tick();
    end
    out_ready = 1'b1;
    expect_px("t2_p0", 8'h11, 2'd0);
    expect_px("t2_p1", 8'h22, 2'd1);
    expect_px("t2_p2", 8'h33, 2'd2);
    expect_px("t2_p3", 8'h44, 2'd3);
    check("t2_empty", out_valid, 0);

    // 3. Out-of-order strobe, then a clean frame
    do_reset();
    pix(1, 8'h5A);
    read3 = 1'b1;
    DATA = 8'h77;
    tick();
    read3 = 1'b0;
    check("t3_seqerr", seq_err, 1);
    check("t3_drop", drop_cnt, 1);
    check("t3_novalid", out_valid, 0);
    tick();
    check("t3_pulse_end", seq_err, 0);
    send_frame(8'hA1, 8'hA2, 8'hA3, 8'hA4);
    wait_valid("t3_valid");
    expect_px("t3_p0", 8'hA1, 2'd0);
    expect_px("t3_p1", 8'hA2, 2'd1);
    expect_px("t3_p2", 8'hA3, 2'd2);
    expect_px("t3_p3", 8'hA4, 2'd3);

    // convert edge mid-frame discards; at frame start it is ignored
    pix(1, 8'h01);
    convert = 1'b1;
    tick();
    check("cv_seqerr", seq_err, 1);
    check("cv_drop", drop_cnt, 2);
    convert = 1'b0;
    tick();
    convert = 1'b1;
    tick();
    check("cv_idle_err", seq_err, 0);
    check("cv_idle_drop", drop_cnt, 2);
    convert = 1'b0;
    tick();
    check("cv_novalid", out_valid, 0);

    // 4. Overflow: five frames into a four-frame FIFO
    do_reset();
    out_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      send_frame(8'(16 * k + 1), 8'(16 * k + 2), 8'(16 * k + 3), 8'(16 * k + 4));
    end
    check("t4_ovf", overflow, 1);
    check("t4_drop", drop_cnt, 1);
    check("t4_seqerr", seq_err, 0);
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      for (int n = 0; n < 4; n++) begin
        check("t4_vld", out_valid, 1);
        expect_px("t4_px", 8'(16 * k + n + 1), 2'(n));
      end
    end
    check("t4_empty", out_valid, 0);
    check("t4_ovf_sticky", overflow, 1);

    // 5. One-cycle strobe ignored, sample taken on the 2nd edge
    do_reset();
    read1 = 1'b1;
    DATA = 8'hEE;
    tick();
    read1 = 1'b0;
    tick();
    check("t5_short_err", seq_err, 0);
    read1 = 1'b1;
    DATA = 8'hA0;
    tick();
    DATA = 8'hB0;
    tick();
    DATA = 8'hC0;
    tick();
    read1 = 1'b0;
    DATA = 8'h00;
    repeat (2) tick();
    pix(2, 8'h52);
    pix(3, 8'h53);
    pix(4, 8'h54);
    wait_valid("t5_valid");
    expect_px("t5_p0", 8'hB0, 2'd0);
    expect_px("t5_p1", 8'h52, 2'd1);
    expect_px("t5_p2", 8'h53, 2'd2);
    expect_px("t5_p3", 8'h54, 2'd3);
    check("t5_drop", drop_cnt, 0);

    // 6. Reset while a frame is half captured and another half output
    do_reset();
    out_ready = 1'b0;
    send_frame(8'h61, 8'h62, 8'h63, 8'h64);
    wait_valid("t6_valid");
    out_ready = 1'b1;
    expect_px("t6_p0", 8'h61, 2'd0);
    expect_px("t6_p1", 8'h62, 2'd1);
    out_ready = 1'b0;
    pix(1, 8'h71);
    read2 = 1'b1;
    DATA = 8'h72;
    repeat (2) tick();
    reset = 1'b1;
    read2 = 1'b0;
    DATA = 8'h00;
    tick();
    check("t6_rst_valid", out_valid, 0);
    check("t6_rst_data", out_data, 0);
    check("t6_rst_idx", out_idx, 0);
    check("t6_rst_err", seq_err, 0);
    check("t6_rst_drop", drop_cnt, 0);
    reset = 1'b0;
    tick();
    check("t6_post_err", seq_err, 0);
    check("t6_post_vld", out_valid, 0);
    out_ready = 1'b1;
    send_frame(8'h81, 8'h82, 8'h83, 8'h84);
    wait_valid("t6_new_valid");
    expect_px("t6_n0", 8'h81, 2'd0);
    expect_px("t6_n1", 8'h82, 2'd1);
    expect_px("t6_n2", 8'h83, 2'd2);
    expect_px("t6_n3", 8'h84, 2'd3);
    check("t6_empty", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
